// File: rtl/usb_device_protocol_fsm.sv
// Device-side USB transaction FSM for a single endpoint: answers IN tokens with DATA,
// OUT tokens with ACK/NAK, and handles host retries, timeouts and the retry limit.
module usb_device_protocol_fsm #(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] DEV_ENDP  = 4'd4,
    parameter logic [7:0] TIMEOUT   = 8'd255,
    parameter logic [3:0] MAX_RETRY = 4'd8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        pkt_received,
    input  logic        crc_correct,
    input  logic [3:0]  pkt_in_pid,
    input  logic [6:0]  pkt_in_addr,
    input  logic [3:0]  pkt_in_endp,
    input  logic [63:0] pkt_in_data,
    input  logic        pkt_sent,
    input  logic        tx_valid,
    input  logic [63:0] tx_data,
    output logic [3:0]  pkt_out_pid,
    output logic [63:0] pkt_out_data,
    output logic        encode,
    output logic        kill,
    output logic        rx_en,
    output logic [63:0] rx_data,
    output logic        rx_data_valid,
    output logic        tx_ack,
    output logic        success,
    output logic        failure
);
    localparam int unsigned PID_W = 4;
    localparam int unsigned DAT_W = 64;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned RTY_W = 4;

    localparam logic [PID_W-1:0] PID_OUT  = 4'b0001;
    localparam logic [PID_W-1:0] PID_IN   = 4'b1001;
    localparam logic [PID_W-1:0] PID_DATA = 4'b0011;
    localparam logic [PID_W-1:0] PID_ACK  = 4'b0010;
    localparam logic [PID_W-1:0] PID_NAK  = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OUT_DATA,
        S_HS_WAIT,
        S_IN_SEND_WAIT,
        S_IN_ACK
    } state_e;

    state_e             state_q, state_d;
    logic               ret_out_q, ret_out_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [PID_W-1:0]   pid_q, pid_d;
    logic [DAT_W-1:0]   data_q, data_d;
    logic [DAT_W-1:0]   rx_data_q, rx_data_d;
    logic               encode_q, encode_d;
    logic               rx_valid_q, rx_valid_d;
    logic               tx_ack_q, tx_ack_d;
    logic               success_q, success_d;
    logic               failure_q, failure_d;

    logic token_hit;
    assign token_hit = pkt_received && crc_correct &&
                       (pkt_in_addr == DEV_ADDR) && (pkt_in_endp == DEV_ENDP);

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        ret_out_d  = ret_out_q;
        clk_cnt_d  = clk_cnt_q;
        retry_d    = retry_q;
        pid_d      = pid_q;
        data_d     = data_q;
        rx_data_d  = rx_data_q;
        encode_d   = 1'b0;
        rx_valid_d = 1'b0;
        tx_ack_d   = 1'b0;
        success_d  = 1'b0;
        failure_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                retry_d   = '0;
                if (token_hit && pkt_in_pid == PID_OUT) begin
                    state_d = S_OUT_DATA;
                end else if (token_hit && pkt_in_pid == PID_IN) begin
                    encode_d = 1'b1;
                    if (tx_valid) begin
                        pid_d   = PID_DATA;
                        data_d  = tx_data;
                        state_d = S_IN_SEND_WAIT;
                    end else begin
                        pid_d     = PID_NAK;
                        ret_out_d = 1'b0;
                        state_d   = S_HS_WAIT;
                    end
                end
            end
            S_OUT_DATA: begin
                if (retry_q == MAX_RETRY) begin
                    failure_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (pkt_received && crc_correct && pkt_in_pid == PID_DATA) begin
                    rx_data_d  = pkt_in_data;
                    rx_valid_d = 1'b1;
                    pid_d      = PID_ACK;
                    encode_d   = 1'b1;
                    success_d  = 1'b1;
                    ret_out_d  = 1'b0;
                    state_d    = S_HS_WAIT;
                end else if (pkt_received && !crc_correct) begin
                    retry_d   = retry_q + RTY_W'(1);
                    clk_cnt_d = '0;
                    pid_d     = PID_NAK;
                    encode_d  = 1'b1;
                    ret_out_d = 1'b1;
                    state_d   = S_HS_WAIT;
                end else if (clk_cnt_q == TIMEOUT) begin
                    failure_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_HS_WAIT: begin
                if (pkt_sent) begin
                    clk_cnt_d = '0;
                    state_d   = ret_out_q ? S_OUT_DATA : S_IDLE;
                end
            end
            S_IN_SEND_WAIT: begin
                if (pkt_sent) begin
                    clk_cnt_d = '0;
                    state_d   = S_IN_ACK;
                end
            end
            S_IN_ACK: begin
                if (retry_q == MAX_RETRY) begin
                    failure_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (pkt_received && crc_correct && pkt_in_pid == PID_ACK) begin
                    tx_ack_d  = 1'b1;
                    success_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (pkt_received || clk_cnt_q == TIMEOUT) begin
                    // Host NAK, garbage or silence: resend whatever the application holds now
                    retry_d  = retry_q + RTY_W'(1);
                    pid_d    = PID_DATA;
                    data_d   = tx_data;
                    encode_d = 1'b1;
                    state_d  = S_IN_SEND_WAIT;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            ret_out_q  <= 1'b0;
            clk_cnt_q  <= '0;
            retry_q    <= '0;
            pid_q      <= '0;
            data_q     <= '0;
            rx_data_q  <= '0;
            encode_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            success_q  <= 1'b0;
            failure_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_out_q  <= ret_out_d;
            clk_cnt_q  <= clk_cnt_d;
            retry_q    <= retry_d;
            pid_q      <= pid_d;
            data_q     <= data_d;
            rx_data_q  <= rx_data_d;
            encode_q   <= encode_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            success_q  <= success_d;
            failure_q  <= failure_d;
        end
    end

    // Receiver listens only while a host packet is expected
    assign rx_en = (state_q == S_IDLE) || (state_q == S_OUT_DATA) || (state_q == S_IN_ACK);

    assign pkt_out_pid   = pid_q;
    assign pkt_out_data  = data_q;
    assign encode        = encode_q;
    assign kill          = encode_q;
    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_valid_q;
    assign tx_ack        = tx_ack_q;
    assign success       = success_q;
    assign failure       = failure_q;

endmodule

// File: tb/tb_usb_device_protocol_fsm.sv
// Self-checking bench for usb_device_protocol_fsm: directed and randomized host transactions
// judged against transaction-level expectations derived from the protocol rules.
module tb_usb_device_protocol_fsm;
    localparam int TO = 255;
    localparam int MR = 8;
    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_DATA = 4'b0011,
                           P_ACK = 4'b0010, P_NAK = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        pkt_received = 1'b0;
    logic        crc_correct = 1'b0;
    logic [3:0]  pkt_in_pid = '0;
    logic [6:0]  pkt_in_addr = '0;
    logic [3:0]  pkt_in_endp = '0;
    logic [63:0] pkt_in_data = '0;
    logic        pkt_sent = 1'b0;
    logic        tx_valid = 1'b0;
    logic [63:0] tx_data = '0;
    logic [3:0]  pkt_out_pid;
    logic [63:0] pkt_out_data;
    logic        encode, kill, rx_en, rx_data_valid, tx_ack, success, failure;
    logic [63:0] rx_data;

    int n_cmp = 0;
    int n_err = 0;

    usb_device_protocol_fsm #(
        .DEV_ADDR(7'd5), .DEV_ENDP(4'd4), .TIMEOUT(8'd255), .MAX_RETRY(4'd8)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .pkt_received(pkt_received), .crc_correct(crc_correct),
        .pkt_in_pid(pkt_in_pid), .pkt_in_addr(pkt_in_addr), .pkt_in_endp(pkt_in_endp),
        .pkt_in_data(pkt_in_data), .pkt_sent(pkt_sent),
        .tx_valid(tx_valid), .tx_data(tx_data),
        .pkt_out_pid(pkt_out_pid), .pkt_out_data(pkt_out_data),
        .encode(encode), .kill(kill), .rx_en(rx_en),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .tx_ack(tx_ack), .success(success), .failure(failure)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                             input logic crc, input logic [63:0] data);
        pkt_received = 1'b1;
        crc_correct  = crc;
        pkt_in_pid   = pid;
        pkt_in_addr  = addr;
        pkt_in_endp  = endp;
        pkt_in_data  = data;
        tick();
        pkt_received = 1'b0;
        crc_correct  = 1'b0;
    endtask

    task automatic drive_sent();
        pkt_sent = 1'b1;
        tick();
        pkt_sent = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({encode, kill, success, failure, rx_data_valid, tx_ack} !== 6'b0) begin
            n_err++; $display("FAIL reset_pulses: got %b exp 000000",
                              {encode, kill, success, failure, rx_data_valid, tx_ack});
        end
        n_cmp++;
        if (pkt_out_pid !== 4'h0 || pkt_out_data !== 64'h0 || rx_data !== 64'h0) begin
            n_err++; $display("FAIL reset_data: pid %h data %h rx %h exp zeros",
                              pkt_out_pid, pkt_out_data, rx_data);
        end
        n_cmp++;
        if (rx_en !== 1'b1) begin n_err++; $display("FAIL reset_rx_en: got %b exp 1", rx_en); end
        ticks(3);
        n_cmp++;
        if ({encode, success, failure, rx_en} !== 4'b0001) begin
            n_err++; $display("FAIL reset_idle: got %b exp 0001", {encode, success, failure, rx_en});
        end
    endtask

    task automatic test_out_basic();
        drive_pkt(P_OUT, 7'd5, 4'd4, 1'b1, 64'h0);
        n_cmp++;
        if ({encode, rx_en} !== 2'b01) begin
            n_err++; $display("FAIL out_token: enc/rx_en %b exp 01", {encode, rx_en});
        end
        ticks(2);
        drive_pkt(P_DATA, 7'd0, 4'd0, 1'b1, 64'hDEAD_BEEF_0123_4567);
        n_cmp++;
        if (rx_data_valid !== 1'b1 || rx_data !== 64'hDEAD_BEEF_0123_4567) begin
            n_err++; $display("FAIL out_rx_data: valid %b data %h exp 1 deadbeef01234567",
                              rx_data_valid, rx_data);
        end
        n_cmp++;
        if ({encode, kill, success, rx_en} !== 4'b1110 || pkt_out_pid !== P_ACK) begin
            n_err++; $display("FAIL out_ack: enc/kill/succ/rx_en %b pid %b exp 1110 0010",
                              {encode, kill, success, rx_en}, pkt_out_pid);
        end
        tick();
        n_cmp++;
        if ({encode, rx_data_valid, success} !== 3'b000 || pkt_out_pid !== P_ACK) begin
            n_err++; $display("FAIL out_pulse_len: pulses %b pid %b exp 000 0010",
                              {encode, rx_data_valid, success}, pkt_out_pid);
        end
        drive_sent();
        tx_valid = 1'b0;
        drive_pkt(P_IN, 7'd5, 4'd4, 1'b1, 64'h0);
        n_cmp++;
        if (encode !== 1'b1 || pkt_out_pid !== P_NAK) begin
            n_err++; $display("FAIL out_back_idle: enc %b pid %b exp 1 1010", encode, pkt_out_pid);
        end
        drive_sent();
    endtask

    task automatic test_in_basic();
        tx_valid = 1'b1;
        tx_data  = 64'hA5A5_A5A5_A5A5_A5A5;
        drive_pkt(P_IN, 7'd5, 4'd4, 1'b1, 64'h0);
        n_cmp++;
        if ({encode, kill, rx_en} !== 3'b110 || pkt_out_pid !== P_DATA ||
            pkt_out_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            n_err++; $display("FAIL in_data: flags %b pid %b data %h exp 110 0011 a5a5..",
                              {encode, kill, rx_en}, pkt_out_pid, pkt_out_data);
        end
        ticks(3);
        drive_sent();
        n_cmp++;
        if ({encode, rx_en} !== 2'b01) begin
            n_err++; $display("FAIL in_listen: enc/rx_en %b exp 01", {encode, rx_en});
        end
        drive_pkt(P_ACK, 7'd0, 4'd0, 1'b1, 64'h0);
        n_cmp++;
        if ({tx_ack, success, encode, failure} !== 4'b1100) begin
            n_err++; $display("FAIL in_ack: txack/succ/enc/fail %b exp 1100",
                              {tx_ack, success, encode, failure});
        end
        tx_valid = 1'b0;
        tick();
    endtask

    task automatic test_mismatch();
        logic [3:0] pids  [5] = '{P_IN, P_OUT, P_IN, P_OUT, P_DATA};
        logic [6:0] addrs [5] = '{7'd6, 7'd6, 7'd5, 7'd5, 7'd5};
        logic [3:0] endps [5] = '{4'd4, 4'd4, 4'd3, 4'd4, 4'd4};
        logic       crcs  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int bad = 0;
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_pkt(pids[i], addrs[i], endps[i], crcs[i], 64'h0);
            if (encode !== 1'b0 || rx_en !== 1'b1) bad++;
            tick();
            if (encode !== 1'b0 || rx_en !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL mismatch_ignored: got %0d responses exp 0", bad); end
        tx_valid = 1'b0;
        drive_pkt(P_IN, 7'd5, 4'd4, 1'b1, 64'h0);
        n_cmp++;
        if (encode !== 1'b1 || pkt_out_pid !== P_NAK || rx_en !== 1'b0) begin
            n_err++; $display("FAIL in_nak: enc %b pid %b rx_en %b exp 1 1010 0", encode, pkt_out_pid, rx_en);
        end
        drive_sent();
        n_cmp++;
        if (rx_en !== 1'b1) begin n_err++; $display("FAIL nak_return: rx_en %b exp 1", rx_en); end
    endtask

    task automatic test_out_corrupt();
        int bad = 0;
        drive_pkt(P_OUT, 7'd5, 4'd4, 1'b1, 64'h0);
        for (int i = 0; i < MR; i++) begin
            drive_pkt(P_DATA, 7'd0, 4'd0, 1'b0, {$urandom, $urandom});
            if (encode !== 1'b1 || pkt_out_pid !== P_NAK || rx_data_valid !== 1'b0 || failure !== 1'b0) bad++;
            tick();
            drive_sent();
            if (rx_en !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL corrupt_naks: got %0d bad NAK steps exp 0", bad); end
        tick();
        n_cmp++;
        if ({failure, encode, success} !== 3'b100) begin
            n_err++; $display("FAIL corrupt_limit: fail/enc/succ %b exp 100", {failure, encode, success});
        end
        tick();
    endtask

    task automatic test_in_timeout();
        int rx_bad = 0;
        int n, exp_n;
        logic got_enc, got_fail;
        tx_valid = 1'b1;
        tx_data  = {$urandom, $urandom};
        drive_pkt(P_IN, 7'd5, 4'd4, 1'b1, 64'h0);
        for (int r = 0; r <= MR; r++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                if (rx_en !== 1'b0) rx_bad++;
                tick();
            end
            if (rx_en !== 1'b0) rx_bad++;
            drive_sent();
            n = 0; got_enc = 1'b0; got_fail = 1'b0;
            while (!got_enc && !got_fail && n < 600) begin
                if (rx_en !== 1'b1) rx_bad++;
                tick();
                n++;
                got_enc  = encode;
                got_fail = failure;
            end
            exp_n = (r < MR) ? TO + 1 : 1;
            n_cmp++;
            if (n !== exp_n || got_enc !== (r < MR) || got_fail !== (r >= MR) ||
                (got_enc && (pkt_out_pid !== P_DATA || pkt_out_data !== tx_data))) begin
                n_err++; $display("FAIL timeout_resend[%0d]: cycles %0d enc %b fail %b pid %b exp %0d %b %b",
                                  r, n, got_enc, got_fail, pkt_out_pid, exp_n, r < MR, r >= MR);
            end
        end
        n_cmp++;
        if (rx_bad !== 0 || rx_en !== 1'b1) begin
            n_err++; $display("FAIL timeout_rx_en: got %0d wrong rx_en cycles exp 0", rx_bad);
        end
        tx_valid = 1'b0;
        tick();
    endtask

    task automatic test_random_out();
        for (int it = 0; it < 6; it++) begin
            int k = $urandom_range(0, MR);
            logic [63:0] payload = {$urandom, $urandom};
            int bad = 0;
            drive_pkt(P_OUT, 7'd5, 4'd4, 1'b1, 64'h0);
            for (int i = 0; i < k; i++) begin
                ticks($urandom_range(0, 5));
                if ($urandom_range(0, 1) == 1) begin
                    drive_pkt(P_ACK, 7'd0, 4'd0, 1'b1, 64'h0);
                    if (encode !== 1'b0) bad++;
                end
                drive_pkt(P_DATA, 7'd0, 4'd0, 1'b0, {$urandom, $urandom});
                if (encode !== 1'b1 || pkt_out_pid !== P_NAK) bad++;
                ticks($urandom_range(0, 3));
                drive_sent();
            end
            if (k < MR) begin
                ticks($urandom_range(0, 5));
                drive_pkt(P_DATA, 7'd0, 4'd0, 1'b1, payload);
                if ({rx_data_valid, success, encode, failure} !== 4'b1110 || rx_data !== payload ||
                    pkt_out_pid !== P_ACK) bad++;
                drive_sent();
            end else begin
                tick();
                if ({failure, success, encode} !== 3'b100) bad++;
            end
            n_cmp++;
            if (bad !== 0) begin
                n_err++; $display("FAIL rand_out[%0d]: k=%0d got %0d wrong steps exp 0", it, k, bad);
            end
            tick();
        end
    endtask

    task automatic test_random_in();
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(0, MR);
            int bad = 0;
            tx_valid = 1'b1;
            tx_data  = {$urandom, $urandom};
            drive_pkt(P_IN, 7'd5, 4'd4, 1'b1, 64'h0);
            if (encode !== 1'b1 || pkt_out_pid !== P_DATA || pkt_out_data !== tx_data) bad++;
            for (int i = 0; i < n; i++) begin
                ticks($urandom_range(0, 3));
                drive_sent();
                ticks($urandom_range(0, 5));
                tx_data = {$urandom, $urandom};
                case ($urandom_range(0, 2))
                    0:       drive_pkt(P_NAK, 7'd0, 4'd0, 1'b1, 64'h0);
                    1:       drive_pkt(P_ACK, 7'd0, 4'd0, 1'b0, 64'h0);
                    default: drive_pkt(P_DATA, 7'd0, 4'd0, 1'b1, 64'h0);
                endcase
                if (encode !== 1'b1 || pkt_out_pid !== P_DATA || pkt_out_data !== tx_data ||
                    tx_ack !== 1'b0) bad++;
            end
            drive_sent();
            if (n < MR) begin
                drive_pkt(P_ACK, 7'd0, 4'd0, 1'b1, 64'h0);
                if ({tx_ack, success, encode, failure} !== 4'b1100) bad++;
            end else begin
                tick();
                if ({tx_ack, success, encode, failure} !== 4'b0001) bad++;
            end
            n_cmp++;
            if (bad !== 0) begin
                n_err++; $display("FAIL rand_in[%0d]: n=%0d got %0d wrong steps exp 0", it, n, bad);
            end
            tick();
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_ack_at_timeout();
        tx_valid = 1'b1;
        tx_data  = {$urandom, $urandom};
        drive_pkt(P_IN, 7'd5, 4'd4, 1'b1, 64'h0);
        drive_sent();
        ticks(TO);
        drive_pkt(P_ACK, 7'd0, 4'd0, 1'b1, 64'h0);
        n_cmp++;
        if ({tx_ack, success, encode, failure} !== 4'b1100) begin
            n_err++; $display("FAIL ack_at_timeout: txack/succ/enc/fail %b exp 1100",
                              {tx_ack, success, encode, failure});
        end
        tx_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        tx_valid = 1'b1;
        tx_data  = {$urandom, $urandom};
        drive_pkt(P_IN, 7'd5, 4'd4, 1'b1, 64'h0);
        #2 rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({encode, kill, success, failure, rx_data_valid, tx_ack} !== 6'b0 ||
            pkt_out_pid !== 4'h0 || pkt_out_data !== 64'h0 || rx_data !== 64'h0 || rx_en !== 1'b1) begin
            n_err++; $display("FAIL reset_mid: pulses %b pid %h data %h rx %h rx_en %b exp zeros rx_en 1",
                              {encode, kill, success, failure, rx_data_valid, tx_ack},
                              pkt_out_pid, pkt_out_data, rx_data, rx_en);
        end
        #3 rst_b = 1'b1;
        drive_sent();
        ticks(2);
        n_cmp++;
        if ({encode, success, failure, rx_en} !== 4'b0001) begin
            n_err++; $display("FAIL reset_mid_idle: enc/succ/fail/rx_en %b exp 0001",
                              {encode, success, failure, rx_en});
        end
        tx_valid = 1'b0;
        drive_pkt(P_IN, 7'd5, 4'd4, 1'b1, 64'h0);
        n_cmp++;
        if (encode !== 1'b1 || pkt_out_pid !== P_NAK) begin
            n_err++; $display("FAIL reset_mid_resume: enc %b pid %b exp 1 1010", encode, pkt_out_pid);
        end
        drive_sent();
    endtask

    initial begin
        #12 rst_b = 1'b1;
        test_reset();
        test_out_basic();
        test_in_basic();
        test_mismatch();
        test_out_corrupt();
        test_in_timeout();
        test_random_out();
        test_random_in();
        test_ack_at_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
